// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction ROM loader.
//  - loader_state_e : 3-bit FSM state encoding (HDR0=0 .. ERR=5)
//  - HdrWidth       : width of the word-count header in bits
//  - NopWord        : value returned for disabled or out-of-range fetches
package inst_rom_loader_pkg;

  typedef enum logic [2:0] {
    StHdr0 = 3'd0,
    StHdr1 = 3'd1,
    StData = 3'd2,
    StCsum = 3'd3,
    StRun  = 3'd4,
    StErr  = 3'd5
  } loader_state_e;

  localparam int unsigned HdrWidth = 16;
  localparam logic [31:0] NopWord  = 32'h0000_0000;

endpackage

// File: rtl/inst_rom_loader_if.sv
// Bus bundle between the instruction ROM loader and its environment.
// It carries the byte-stream load port, the reload pulse, the CPU fetch port and the status
// outputs.
//  master : the environment (stream source + CPU); drives load/fetch requests
//  slave  : the loader; drives load_ready, rom_data and the status flags
interface inst_rom_loader_if;

  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        reload;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        cpu_rst;
  logic        done;
  logic        err;

  modport master (
    output load_valid, load_data, reload, rom_ce, rom_addr,
    input  load_ready, rom_data, cpu_rst, done, err
  );

  modport slave (
    input  load_valid, load_data, reload, rom_ce, rom_addr,
    output load_ready, rom_data, cpu_rst, done, err
  );

endinterface

// File: rtl/inst_rom_loader_ram.sv
// Instruction RAM: DEPTH x 32 bits, one synchronous write port and one asynchronous read port.
// Contents have no reset.
//  clk_i   : write clock
//  we_i    : write enable
//  waddr_i : write word index
//  wdata_i : write data
//  raddr_i : read word index
//  rdata_o : read data (combinational)
module inst_rom_loader_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_rom_loader.sv
// Boot-time instruction store upstream of the CPU fetch port.
// It receives a program as a byte stream and writes it into word RAM, and it holds the CPU in
// reset until the load completes. After that it serves fetches with same-cycle read data.
// Stream: 16-bit word count N (MSB first), then N big-endian 32-bit words.
// Optional feature macro: LOADER_CHECKSUM_EN. When it is defined, one trailing byte holds the
// XOR of all data bytes; a match enters RUN and a mismatch enters ERR.
// Ports:
//  clk    : single clock, rising edge
//  rst    : synchronous active-high reset
//  bus_io : slave side of inst_rom_loader_if (load stream, reload, fetch, status)
// DEPTH is the RAM size in words and must not exceed 32768.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input logic                     clk,
  input logic                     rst,
  inst_rom_loader_if.slave        bus_io
);

  localparam int unsigned AW = $clog2(DEPTH);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e StAfterData = StCsum;
`else
  localparam loader_state_e StAfterData = StRun;
`endif

  loader_state_e         state_q, state_d;
  logic [HdrWidth-1:0]   n_q, n_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [23:0]           asm_q, asm_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic                  load_ready;
  logic                  accept;
  logic [HdrWidth-1:0]   n_full;
  logic [AW:0]           n_last;
  logic                  last_word;

  logic                  ram_we;
  logic [31:0]           ram_wdata;
  logic [AW-1:0]         rd_idx;
  logic [31:0]           ram_rdata;
  logic                  rd_in_range;
  logic                  unused_addr_lsbs;

  assign accept    = bus_io.load_valid && load_ready;
  // Full header value as seen on the edge that accepts its low byte.
  assign n_full    = {n_q[HdrWidth-1:8], bus_io.load_data};
  // N >= 1 whenever DATA is active, so N-1 never wraps there.
  assign n_last    = n_q[AW:0] - {{AW{1'b0}}, 1'b1};
  assign last_word = ({1'b0, idx_q} == n_last);

  // Outputs are decoded from the state register so cpu_rst drops the cycle after the last byte.
  always_comb begin
    load_ready = 1'b0;
    unique case (state_q)
      StHdr0, StHdr1, StData, StCsum: load_ready = !rst;
      default:                        load_ready = 1'b0;
    endcase
  end

  assign bus_io.load_ready = load_ready;
  assign bus_io.cpu_rst    = rst || (state_q != StRun);
  assign bus_io.done       = !rst && (state_q == StRun);
  assign bus_io.err        = !rst && (state_q == StErr);

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    bcnt_d    = bcnt_q;
    asm_d     = asm_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    ram_we    = 1'b0;
    ram_wdata = {asm_q, bus_io.load_data};

    unique case (state_q)
      StHdr0: begin
        if (accept) begin
          n_d[HdrWidth-1:8] = bus_io.load_data;
          state_d           = StHdr1;
        end
      end
      StHdr1: begin
        if (accept) begin
          n_d    = n_full;
          idx_d  = '0;
          bcnt_d = 2'd0;
          if (n_full == '0) begin
            state_d = StAfterData;
          end else if ({16'h0, n_full} > DEPTH) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus_io.load_data;
`endif
          if (bcnt_q == 2'd3) begin
            // Fourth byte completes the word; it is written on this same edge.
            ram_we = 1'b1;
            bcnt_d = 2'd0;
            if (last_word) begin
              state_d = StAfterData;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            asm_d  = {asm_q[15:0], bus_io.load_data};
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCsum: begin
        if (accept) begin
          state_d = (bus_io.load_data == csum_q) ? StRun : StErr;
        end
      end
`endif
      StRun, StErr: begin
        state_d = state_q;
      end
      default: begin
        state_d = StHdr0;
      end
    endcase

    // Reload overrides everything and drops any partially assembled word.
    if (bus_io.reload) begin
      state_d = StHdr0;
      n_d     = '0;
      idx_d   = '0;
      bcnt_d  = 2'd0;
      asm_d   = '0;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = '0;
`endif
      ram_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StHdr0;
      n_q     <= '0;
      idx_q   <= '0;
      bcnt_q  <= 2'd0;
      asm_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  inst_rom_loader_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we && !rst),
    .waddr_i (idx_q),
    .wdata_i (ram_wdata),
    .raddr_i (rd_idx),
    .rdata_o (ram_rdata)
  );

  // Fetch path: byte address to word index; the upper bits must be zero and the index must be
  // below DEPTH, otherwise the fetch reads as a NOP.
  assign rd_idx           = bus_io.rom_addr[AW+1:2];
  assign unused_addr_lsbs = ^bus_io.rom_addr[1:0];
  assign rd_in_range      = (bus_io.rom_addr[31:AW+2] == '0) &&
                            ({{(32-AW){1'b0}}, rd_idx} < DEPTH);
  assign bus_io.rom_data  = (bus_io.rom_ce && rd_in_range) ? ram_rdata : NopWord;

endmodule

// File: tb/tb_inst_rom_loader.sv
module tb_inst_rom_loader;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  localparam int unsigned Depth = 1024;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  logic [31:0] exp_mem [Depth];
  bit          exp_vld [Depth];

  inst_rom_loader_if bus ();

  inst_rom_loader #(
    .DEPTH (Depth)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream image from the format rules: header, big-endian words, optional XOR trailer.
  function automatic byte_q_t build_stream(input word_q_t words, input bit good_csum);
    byte_q_t    s;
    logic [7:0] x;
    logic [15:0] n;
    n = 16'(words.size());
    x = 8'h00;
    s.push_back(n[15:8]);
    s.push_back(n[7:0]);
    foreach (words[i]) begin
      for (int k = 3; k >= 0; k--) begin
        logic [7:0] b;
        b = words[i][8*k +: 8];
        s.push_back(b);
        x = x ^ b;
      end
    end
`ifdef LOADER_CHECKSUM_EN
    s.push_back(good_csum ? x : (x ^ 8'h04));
`else
    if (!good_csum) s.push_back(x);
`endif
    return s;
  endfunction

  // gap < 0 selects a random 0..2 idle cycles before each byte.
  task automatic send_stream(input byte_q_t s, input int gap);
    for (int i = 0; i < s.size(); i++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        bus.load_valid = 1'b0;
        tick();
      end
      bus.load_valid = 1'b1;
      bus.load_data  = s[i];
      check("load_ready_in_load", 32'(bus.load_ready), 32'd1);
      if (i == s.size() - 1) check("cpu_rst_before_last", 32'(bus.cpu_rst), 32'd1);
      tick();
      bus.load_valid = 1'b0;
    end
  endtask

  task automatic model_load(input word_q_t words);
    foreach (words[i]) begin
      exp_mem[i] = words[i];
      exp_vld[i] = 1'b1;
    end
  endtask

  task automatic check_word(input string tag, input int i);
    bus.rom_ce   = 1'b1;
    bus.rom_addr = 32'(i * 4) + 32'($urandom_range(0, 3));
    #1;
    check(tag, bus.rom_data, exp_mem[i]);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      if (exp_vld[i]) check_word(tag, i);
    end
  endtask

  task automatic expect_run(input string tag);
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_cpu_rst"}, 32'(bus.cpu_rst), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
    check({tag, "_ready"}, 32'(bus.load_ready), 32'd0);
  endtask

  task automatic pulse_reload();
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    check("reload_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("reload_done", 32'(bus.done), 32'd0);
    check("reload_err", 32'(bus.err), 32'd0);
    check("reload_ready", 32'(bus.load_ready), 32'd1);
  endtask

  initial begin
    word_q_t basic;
    word_q_t w;
    byte_q_t s;
    tests  = 0;
    failed = 0;
    for (int i = 0; i < int'(Depth); i++) exp_vld[i] = 1'b0;
    rst            = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    bus.reload     = 1'b0;
    bus.rom_ce     = 1'b0;
    bus.rom_addr   = 32'h0;

    // Reset state.
    tick();
    tick();
    check("rst_ready", 32'(bus.load_ready), 32'd0);
    check("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.load_ready), 32'd1);

    // Basic load, no backpressure.
    basic = '{32'h3401_1100, 32'h3402_0020};
    send_stream(build_stream(basic, 1'b1), 0);
    model_load(basic);
    expect_run("basic");
    bus.rom_ce   = 1'b1;
    bus.rom_addr = 32'h4;
    #1;
    check("basic_fetch4", bus.rom_data, exp_mem[1]);
    check_all("basic_word");

    // Gapped valid.
    pulse_reload();
    send_stream(build_stream(basic, 1'b1), 1);
    expect_run("gapped");
    check_all("gapped_word");

    // Fetch bounds.
    bus.rom_ce = 1'b0; bus.rom_addr = 32'h0; #1;
    check("fetch_ce0", bus.rom_data, 32'h0);
    bus.rom_ce = 1'b1; bus.rom_addr = 32'h0000_1000; #1;
    check("fetch_oob", bus.rom_data, 32'h0);
    bus.rom_addr = 32'h8000_0004; #1;
    check("fetch_oob_msb", bus.rom_data, 32'h0);
    bus.rom_addr = 32'h3; #1;
    check("fetch_addr3", bus.rom_data, exp_mem[0]);

    // Reset pulse while running keeps RAM.
    rst = 1'b1;
    tick();
    check("rst_run_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("rst_run_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    #1;
    check_all("rst_run_word");

    // Oversize header: N = 1025.
    s = '{8'h04, 8'h01};
    send_stream(s, 0);
    check("over_err", 32'(bus.err), 32'd1);
    check("over_ready", 32'(bus.load_ready), 32'd0);
    check("over_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("over_done", 32'(bus.done), 32'd0);
    check_all("over_word");

    // Reload mid-word: the partial second word must not reach RAM.
    pulse_reload();
    s = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
    send_stream(s, 0);
    exp_mem[0] = 32'h1122_3344;
    check("midword_done", 32'(bus.done), 32'd0);
    pulse_reload();
    w = '{32'hDEAD_BEEF};
    send_stream(build_stream(w, 1'b1), 0);
    model_load(w);
    expect_run("midword");
    check_all("midword_word");

    // Empty program.
    pulse_reload();
    w = {};
    send_stream(build_stream(w, 1'b1), 0);
    expect_run("n0");

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum byte.
    pulse_reload();
    send_stream(build_stream(basic, 1'b0), 0);
    model_load(basic);
    check("csum_bad_err", 32'(bus.err), 32'd1);
    check("csum_bad_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("csum_bad_done", 32'(bus.done), 32'd0);
`endif

    // Random programs with random gaps.
    for (int it = 0; it < 6; it++) begin
      int n;
      pulse_reload();
      n = int'($urandom_range(1, 12));
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      send_stream(build_stream(w, 1'b1), -1);
      model_load(w);
      expect_run("rand");
      check_all("rand_word");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
